// File: rtl/freq_gate_cnt_if.sv
// -----------------------------------------------------------------------------
// freq_gate_cnt_if
//   Groups the measurement signals of freq_gate_cnt. The clock and reset stay
//   plain ports on the module.
//
//   test_sig       unknown-frequency input, asynchronous to sys_clk
//   test_Freq      28-bit count of test_sig periods in the last gate
//   stand_Freq     28-bit count of sys_clk cycles in the last gate
//   calc_flag_reg  one-cycle strobe, a new result is valid
//   ovf            a counter saturated during the last gate
//
//   slave  : the measuring block (drives the results)
//   master : the consumer / signal source (drives test_sig)
// -----------------------------------------------------------------------------
interface freq_gate_cnt_if;
  logic        test_sig;
  logic [27:0] test_Freq;
  logic [27:0] stand_Freq;
  logic        calc_flag_reg;
  logic        ovf;

  modport master (
    output test_sig,
    input  test_Freq,
    input  stand_Freq,
    input  calc_flag_reg,
    input  ovf
  );

  modport slave (
    input  test_sig,
    output test_Freq,
    output stand_Freq,
    output calc_flag_reg,
    output ovf
  );
endinterface

// File: rtl/freq_gate_cnt.sv
// -----------------------------------------------------------------------------
// freq_gate_cnt
//   Reciprocal-style frequency counter. A soft gate of at least GATE_CYCLES
//   sys_clk cycles is opened on one rising edge of test_sig and closed on the
//   first rising edge after the soft gate expires, so both counters cover a
//   whole number of test_sig periods:
//     f_test = f_sys * test_Freq / stand_Freq
//
// Ports
//   sys_clk    system clock, everything runs on its rising edge
//   sys_rst_n  asynchronous active-low reset
//   fif        freq_gate_cnt_if.slave: test_sig in; test_Freq, stand_Freq,
//              calc_flag_reg, ovf out (all outputs registered)
//
// Parameters
//   GATE_CYCLES     minimum soft-gate length in sys_clk cycles (>= 1)
//   TIMEOUT_CYCLES  edge-wait limit in sys_clk cycles (timeout build only)
//
// Build option
//   FREQ_TIMEOUT_EN  when defined, a wait counter runs in S_WAIT and S_CLOSE;
//                    if no edge arrives within TIMEOUT_CYCLES a zero result
//                    (0/0, ovf=0) is published with the normal strobe timing.
//                    When undefined, both states wait for an edge forever.
// -----------------------------------------------------------------------------
module freq_gate_cnt #(
  parameter logic [27:0] GATE_CYCLES    = 28'd50_000_000,
  parameter logic [27:0] TIMEOUT_CYCLES = 28'd100_000_000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  freq_gate_cnt_if.slave fif
);

  localparam logic [27:0] CNT_MAX = 28'hFFF_FFFF;

  typedef enum logic [1:0] {
    S_WAIT,   // counters cleared, waiting for the opening edge
    S_MEAS,   // soft gate running for GATE_CYCLES cycles
    S_CLOSE,  // soft gate expired, waiting for the closing edge
    S_PUB     // load the result registers
  } state_t;

  state_t      state;

  // Synchronizer and edge detector
  logic        sync_meta;
  logic        sync_stable;
  logic        edge_q;
  logic        tedge;

  // Measurement counters
  logic [27:0] gate_cnt;
  logic [27:0] stand_cnt;
  logic [27:0] test_cnt;
  logic        sat_sticky;

  // Result registers
  logic [27:0] test_freq_q;
  logic [27:0] stand_freq_q;
  logic        ovf_q;
  logic        pub_strobe;
  logic        calc_flag_q;

`ifdef FREQ_TIMEOUT_EN
  logic [27:0] wait_cnt;
  logic        wait_hit;
  logic        timed_out;
`endif

  // A zero-length gate or timeout would make the terminal-count compares
  // below wrap to all ones, so refuse such a configuration at elaboration.
  if (GATE_CYCLES == 28'd0 || TIMEOUT_CYCLES == 28'd0) begin : g_param_check
    $error("freq_gate_cnt: GATE_CYCLES and TIMEOUT_CYCLES must be non-zero");
  end

  // ---------------------------------------------------------------------------
  // test_sig synchronizer: two flops against metastability, a third one
  // remembers the previous level so tedge is a single-cycle rising-edge pulse.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of the others; a blocking '=' here
  // would collapse the three-flop chain into one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_meta   <= 1'b0;
      sync_stable <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      sync_meta   <= fif.test_sig;
      sync_stable <= sync_meta;
      edge_q      <= sync_stable;
    end
  end

  assign tedge = sync_stable & ~edge_q;

  // Saturating increment: holds at CNT_MAX instead of wrapping to zero.
  function automatic logic [27:0] sat_inc(input logic [27:0] value);
    return (value == CNT_MAX) ? value : value + 28'd1;
  endfunction

`ifdef FREQ_TIMEOUT_EN
  // The wait counter restarts on every state change, so it measures the time
  // spent in the current waiting state without an edge.
  assign wait_hit = (wait_cnt == TIMEOUT_CYCLES - 28'd1);
`endif

  // ---------------------------------------------------------------------------
  // Measurement FSM with registered results.
  // Timeline for an opening edge at cycle 0: S_MEAS covers cycles
  // 1..GATE_CYCLES, an edge on the last of those is still counted and only a
  // later edge (in S_CLOSE) closes the gate. stand_cnt therefore equals the
  // cycle distance between the opening and closing edges.
  // The result registers load as S_PUB is left; calc_flag_reg follows one
  // cycle later so a consumer sees stable data at the strobe's rising edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_WAIT;
      gate_cnt     <= '0;
      stand_cnt    <= '0;
      test_cnt     <= '0;
      sat_sticky   <= 1'b0;
      test_freq_q  <= '0;
      stand_freq_q <= '0;
      ovf_q        <= 1'b0;
      pub_strobe   <= 1'b0;
      calc_flag_q  <= 1'b0;
`ifdef FREQ_TIMEOUT_EN
      wait_cnt     <= '0;
      timed_out    <= 1'b0;
`endif
    end else begin
      pub_strobe  <= 1'b0;
      calc_flag_q <= pub_strobe;

      case (state)
        S_WAIT: begin
          gate_cnt  <= '0;
          stand_cnt <= '0;
          test_cnt  <= '0;
          if (tedge) begin
            // Opening edge: this cycle is cycle 0 of the gate.
            state      <= S_MEAS;
            sat_sticky <= 1'b0;
          end
`ifdef FREQ_TIMEOUT_EN
          else if (wait_hit) begin
            state     <= S_PUB;
            timed_out <= 1'b1;
          end
          wait_cnt <= (tedge || wait_hit) ? 28'd0 : wait_cnt + 28'd1;
`endif
        end

        S_MEAS: begin
          stand_cnt <= sat_inc(stand_cnt);
          gate_cnt  <= gate_cnt + 28'd1;
          if (tedge) begin
            test_cnt <= sat_inc(test_cnt);
          end
          if (stand_cnt == CNT_MAX || (tedge && test_cnt == CNT_MAX)) begin
            sat_sticky <= 1'b1;
          end
          if (gate_cnt == GATE_CYCLES - 28'd1) begin
            state <= S_CLOSE;
          end
`ifdef FREQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        S_CLOSE: begin
          stand_cnt <= sat_inc(stand_cnt);
          if (stand_cnt == CNT_MAX || (tedge && test_cnt == CNT_MAX)) begin
            sat_sticky <= 1'b1;
          end
          if (tedge) begin
            // Closing edge: counted, and consumed here so it cannot reopen.
            test_cnt <= sat_inc(test_cnt);
            state    <= S_PUB;
          end
`ifdef FREQ_TIMEOUT_EN
          else if (wait_hit) begin
            state     <= S_PUB;
            timed_out <= 1'b1;
          end
          wait_cnt <= (tedge || wait_hit) ? 28'd0 : wait_cnt + 28'd1;
`endif
        end

        S_PUB: begin
`ifdef FREQ_TIMEOUT_EN
          test_freq_q  <= timed_out ? 28'd0 : test_cnt;
          stand_freq_q <= timed_out ? 28'd0 : stand_cnt;
          ovf_q        <= timed_out ? 1'b0  : sat_sticky;
          timed_out    <= 1'b0;
          wait_cnt     <= '0;
`else
          test_freq_q  <= test_cnt;
          stand_freq_q <= stand_cnt;
          ovf_q        <= sat_sticky;
`endif
          pub_strobe   <= 1'b1;
          state        <= S_WAIT;
        end

        default: state <= S_WAIT;
      endcase
    end
  end

  assign fif.test_Freq     = test_freq_q;
  assign fif.stand_Freq    = stand_freq_q;
  assign fif.ovf           = ovf_q;
  assign fif.calc_flag_reg = calc_flag_q;

endmodule

// File: doc/freq_gate_cnt.md
FREQ_GATE_CNT -- requirements
Module: freq_gate_cnt

Interface
REQ-001 Parameter: GATE_CYCLES, default 28'd50_000_000, minimum soft-gate length in sys_clk cycles.
REQ-002 Parameter: TIMEOUT_CYCLES, default 28'd100_000_000, edge-wait limit in sys_clk cycles (used only with FREQ_TIMEOUT_EN).
REQ-003 Port: sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: test_sig  input  1  unknown-frequency signal, asynchronous to sys_clk.
REQ-006 Port: test_Freq  output  28  registered count of test_sig periods in the last gate.
REQ-007 Port: stand_Freq  output  28  registered count of sys_clk cycles in the last gate.
REQ-008 Port: calc_flag_reg  output  1  one-cycle strobe: new result valid.
REQ-009 Port: ovf  output  1  registered flag: a counter saturated in the last gate.

Function
REQ-010 test_sig SHALL pass through a 2-flop synchronizer plus 1 edge flop; rising edge "tedge" is a 1-cycle pulse, 3 cycles input-to-pulse.
REQ-011 FSM states: S_WAIT, S_MEAS, S_CLOSE, S_PUB; reset state S_WAIT.
REQ-012 S_WAIT: counters held at 0; tedge -> S_MEAS (opening edge, cycle 0).
REQ-013 S_MEAS: stand_cnt +1 every cycle, test_cnt +1 per tedge, gate_cnt +1 per cycle; after GATE_CYCLES cycles in S_MEAS -> S_CLOSE.
REQ-014 tedge on the final S_MEAS cycle SHALL be counted and SHALL NOT close the gate.
REQ-015 S_CLOSE: stand_cnt +1 every cycle; first tedge increments test_cnt and moves to S_PUB (closing edge).
REQ-016 stand_cnt at close SHALL equal exact cycle distance between opening and closing tedge; test_cnt SHALL equal tedges after opening, closing edge included.
REQ-017 Counters SHALL saturate at 28'hFFFFFFF, never wrap; saturation sets an internal sticky flag cleared on entry to S_MEAS.
REQ-018 S_PUB (one cycle): load test_Freq, stand_Freq, ovf from counters/sticky flag; next cycle -> S_WAIT.
REQ-019 calc_flag_reg SHALL be high exactly one cycle, the cycle after outputs update, so outputs are stable at its rising edge.
REQ-020 Outputs SHALL hold value between publishes; back-to-back measurements need no external trigger.
REQ-021 Closing tedge SHALL NOT open the next gate; next measurement opens on a later tedge in S_WAIT.

Reset
REQ-022 sys_rst_n low SHALL asynchronously clear test_Freq, stand_Freq, ovf, calc_flag_reg, all counters, synchronizer flops, FSM to S_WAIT.
REQ-023 Reset mid-measurement SHALL discard the partial gate; no strobe until a full gate completes after release.

Configuration
REQ-024 Macro FREQ_TIMEOUT_EN defined: wait counter runs in S_WAIT and S_CLOSE, cleared on tedge/state change; reaching TIMEOUT_CYCLES publishes test_Freq=0, stand_Freq=0, ovf=0 with normal calc_flag_reg timing, then S_WAIT.
REQ-025 Macro FREQ_TIMEOUT_EN undefined: no wait counter; S_WAIT and S_CLOSE wait indefinitely for tedge.

Verification (GATE_CYCLES=100, TIMEOUT_CYCLES=500 in bench)
REQ-026 test_sig period 10 cycles, edges aligned -> test_Freq=11, stand_Freq=110, ovf=0, one calc_flag_reg pulse the cycle after update.
REQ-027 test_sig period 7 cycles -> test_Freq=15, stand_Freq=105; consecutive results identical, no missed gates.
REQ-028 sys_rst_n pulsed low 50 cycles into S_MEAS -> all outputs 0 immediately; next result equals a clean gate (11/110 for period 10).
REQ-029 test_sig held low 600 cycles: with FREQ_TIMEOUT_EN -> 0/0 published, calc_flag_reg pulses; without -> calc_flag_reg stays 0.
REQ-030 Force stand_cnt near saturation (GATE_CYCLES=28'hFFFFFF0, period 64) -> stand_Freq=28'hFFFFFFF, ovf=1; next normal gate clears ovf.
